// File: rtl/sub_share_arbiter.sv
// rtl/sub_share_arbiter.sv - round-robin arbiter sharing one subtractor among NUM_REQ requesters
module realSubstractor #(
  parameter int DATA_WIDTH = 22
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] diff
);
  assign diff = a - b;
endmodule

module sub_share_arbiter #(
  parameter int DATA_WIDTH = 22,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          out_ovf,
  input  logic                          out_ready
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   ptr;
  logic                  lock_vld;
  logic [ID_WIDTH-1:0]   lock_id;
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   search_id;
  logic                  search_found;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  grant_valid;
  logic                  can_issue;
  logic                  take;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;
  logic [DATA_WIDTH-1:0] diff;
  logic                  ovf;

  // Explicit wrap keeps the pointer in range when NUM_REQ is not a power of two.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + ID_WIDTH'(1);
  endfunction

  always_comb begin
    search_found = 1'b0;
    search_id    = '0;
    cand         = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!search_found && req_valid[cand]) begin
        search_found = 1'b1;
        search_id    = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // A stalled grant is pinned so the held operands are the ones eventually consumed.
  assign grant_valid = lock_vld ? req_valid[lock_id] : search_found;
  assign grant_id    = lock_vld ? lock_id : search_id;
  assign can_issue   = !out_valid || out_ready;
  assign take        = grant_valid && can_issue;

  always_comb begin
    req_ready = '0;
    if (rst_n && take) req_ready[grant_id] = 1'b1;
  end

  assign a_sel = req_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign b_sel = req_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

  realSubstractor #(.DATA_WIDTH(DATA_WIDTH)) u_sub (
    .a    (a_sel),
    .b    (b_sel),
    .diff (diff)
  );

  assign ovf = (a_sel[DATA_WIDTH-1] != b_sel[DATA_WIDTH-1]) &&
               (diff[DATA_WIDTH-1] != a_sel[DATA_WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_ovf   <= 1'b0;
      ptr       <= '0;
      lock_vld  <= 1'b0;
      lock_id   <= '0;
    end else begin
      if (take) begin
        out_data <= diff;
        out_id   <= grant_id;
        out_ovf  <= ovf;
        ptr      <= wrap_inc(grant_id);
        lock_vld <= 1'b0;
      end else if (grant_valid) begin
        lock_vld <= 1'b1;
        lock_id  <= grant_id;
      end
      case (state)
        EMPTY: begin
          if (take) begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (out_ready && !take) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb/tb_sub_share_arbiter.sv - scoreboard bench for sub_share_arbiter
module tb_sub_share_arbiter;
  localparam int DW = 22;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic             out_valid, out_ready, out_ovf;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_id;

  sub_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ovf(out_ovf), .out_ready(out_ready)
  );

  logic          rst3_n;
  logic [2:0]    rv3, rr3;
  logic [3*DW-1:0] ra3, rb3;
  logic          ov3, or3, ovf3;
  logic [DW-1:0] od3;
  logic [1:0]    oid3;

  sub_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(rv3), .req_a(ra3), .req_b(rb3),
    .req_ready(rr3), .out_valid(ov3), .out_data(od3), .out_id(oid3),
    .out_ovf(ovf3), .out_ready(or3)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          ovf;
  } res_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  res_t    sb[$];
  int      seen_ids[$];
  int      m_ptr, m_lock;
  bit      m_full;
  bit [NR-1:0] accepted;
  bit      n3_done = 1'b0;
  res_t    e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference subtraction on true signed integers; overflow = result outside the DW-bit range.
  function automatic res_t model_sub(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b);
    res_t   r;
    longint lim = longint'(1) << (DW - 1);
    longint sa  = a[DW-1] ? longint'(a) - (longint'(1) << DW) : longint'(a);
    longint sb_ = b[DW-1] ? longint'(b) - (longint'(1) << DW) : longint'(b);
    longint d   = sa - sb_;
    r.id   = id;
    r.data = d[DW-1:0];
    r.ovf  = (d >= lim) || (d < -lim);
    return r;
  endfunction

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 22'h1FFFFF;
      1:       return 22'h200000;
      2:       return '0;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_lock = -1;
    m_full = 1'b0;
    sb.delete();
  endtask

  // One cycle: predict the grant at the negedge, then let the edge happen.
  task automatic tick();
    int            g;
    bit            can;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(m_full));
    can = !m_full || out_ready;
    g   = -1;
    if (m_lock >= 0) g = m_lock;
    else
      for (int k = 0; k < NR; k++)
        if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    exp_ready = '0;
    if (g >= 0 && can) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    accepted = '0;
    if (g >= 0 && can) begin
      sb.push_back(model_sub(g, req_a[g*DW +: DW], req_b[g*DW +: DW]));
      accepted[g] = 1'b1;
      m_ptr  = (g + 1) % NR;
      m_lock = -1;
      m_full = 1'b1;
    end else begin
      if (g >= 0) m_lock = g;
      if (m_full && out_ready) m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (accepted[i]) req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_seen(input string name, input int exp_ids[$]);
    check({name, "_len"}, 64'(seen_ids.size()), 64'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < seen_ids.size(); i++)
      check(name, 64'(seen_ids[i]), 64'(exp_ids[i]));
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got out_id %0d with no expected result", out_id);
      end else begin
        e = sb.pop_front();
        check("out_id", 64'(out_id), 64'(e.id));
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_ovf", 64'(out_ovf), 64'(e.ovf));
        seen_ids.push_back(int'(out_id));
      end
    end
  end

  initial begin
    int cnt = 0;
    rst3_n = 1'b0;
    rv3    = 3'b111;
    or3    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ra3[i*DW +: DW] = DW'(50);
      rb3[i*DW +: DW] = DW'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    rst3_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ov3) begin
        check("n3_id", 64'(oid3), 64'(cnt % 3));
        check("n3_data", 64'(od3), 64'(50 - (cnt % 3)));
        cnt++;
      end
    end
    check("n3_count", 64'(cnt), 64'(9));
    n3_done = 1'b1;
  end

  initial begin
    logic [DW-1:0] d0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_id", 64'(out_id), 64'(0));
    check("rst_out_ovf", 64'(out_ovf), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    req_valid = '0;
    rst_n     = 1'b1;

    out_ready = 1'b1;
    set_req(0, DW'(100), DW'(30));
    tick();
    check("single_data", 64'(out_data), 64'(70));
    check("single_id", 64'(out_id), 64'(0));
    check("single_ovf", 64'(out_ovf), 64'(0));
    tick();

    do_reset();
    seen_ids.delete();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NR; i++) if (!req_valid[i]) set_req(i, pick(), pick());
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    check_seen("rr_seq", '{0, 1, 2, 3, 0});

    do_reset();
    seen_ids.delete();
    out_ready = 1'b1;
    set_req(3, DW'(9), DW'(4));
    tick();
    out_ready = 1'b0;
    set_req(2, DW'(20), DW'(1));
    tick();
    d0 = out_data;
    set_req(0, DW'(7), DW'(7));
    set_req(3, DW'(8), DW'(2));
    tick();
    check("lock_stable", 64'(out_data), 64'(d0));
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    check_seen("lock_seq", '{3, 2, 3, 0});

    set_req(1, 22'h1FFFFF, 22'h3FFFFF);
    tick();
    check("ovf_data", 64'(out_data), 64'(22'h200000));
    check("ovf_flag", 64'(out_ovf), 64'(1));
    set_req(2, DW'(5), DW'(7));
    tick();
    check("neg_data", 64'(out_data), 64'(22'h3FFFFE));
    check("neg_flag", 64'(out_ovf), 64'(0));
    tick();

    out_ready = 1'b0;
    set_req(1, DW'(3), DW'(1));
    tick();
    set_req(2, DW'(6), DW'(2));
    tick();
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'(0));
    check("async_req_ready", 64'(req_ready), 64'(0));
    model_reset();
    req_valid = 4'b0100;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();

    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, pick(), pick());
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && (req_valid != '0 || sb.size() != 0); c++) tick();
    check("drain_sb", 64'(sb.size()), 64'(0));
    check("drain_valid", 64'(req_valid), 64'(0));
    check("n3_done", 64'(n3_done), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sub_share_arbiter.md
# sub_share_arbiter

Round-robin arbiter that time-shares one `realSubstractor` instance (two's-complement A−B, `DATA_WIDTH` bits) among `NUM_REQ` requesters in the temporal-convolution core. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the difference together with the requester ID and a signed-overflow flag, and drives it downstream with its own valid/ready handshake. Throughput is one subtraction per cycle when the output is not back-pressured.

## Interface
- `DATA_WIDTH`, 22, operand and result width (two's complement).
- `NUM_REQ`, 4, number of requesters (≥2).
- `ID_WIDTH`, $clog2(`NUM_REQ`), derived; do not override.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  bit i: requester i has an operand pair.
- `req_a`  in  `NUM_REQ`*`DATA_WIDTH`  minuend; slice i = bits [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `req_b`  in  `NUM_REQ`*`DATA_WIDTH`  subtrahend; packed the same way as `req_a`.
- `req_ready`  out  `NUM_REQ`  one-hot or zero; bit i: pair i accepted this cycle.
- `out_valid`  out  1  result register holds a result.
- `out_data`  out  `DATA_WIDTH`  A−B, modulo 2^`DATA_WIDTH`.
- `out_id`  out  `ID_WIDTH`  index of the requester that produced `out_data`.
- `out_ovf`  out  1  signed overflow of that subtraction.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- Transfer on requester i: `req_valid[i] && req_ready[i]`. Transfer on the output: `out_valid && out_ready`.
- Requesters hold `req_valid`, `req_a` and `req_b` stable until their transfer. The block never requires a valid to drop.
- `can_issue = !out_valid || out_ready`.
- Priority pointer `ptr` (`ID_WIDTH` bits, reset 0). Search starts at index `ptr` and wraps modulo `NUM_REQ`. The first asserted `req_valid` wins the grant.
- Grant lock register (`lock_vld`, `lock_id`):
  - Set when a grant exists but `can_issue` = 0.
  - While the lock is set, the grant is forced to `lock_id`, even if a higher-priority requester raises valid.
  - Cleared on the transfer of the locked requester.
- `req_ready[g] = grant_valid && can_issue`. All other bits are 0.
- On a transfer from requester g:
  - `out_data <= a_g − b_g` (through the `realSubstractor` instance).
  - `out_id <= g`.
  - `out_ovf <= (a_g[MSB] != b_g[MSB]) && (diff[MSB] != a_g[MSB])`.
  - `out_valid <= 1`.
  - `ptr <= (g+1) mod NUM_REQ`.
- On an output transfer with no new requester transfer: `out_valid <= 0`. Data, ID and overflow registers keep their last values.
- Simultaneous output transfer and new requester transfer in the same cycle: the new result replaces the old one and `out_valid` stays 1 (no bubble).
- FSM with two states:
  - EMPTY (`out_valid`=0): moves to FULL on a requester transfer.
  - FULL: stays FULL on a stall or on a simultaneous transfer. Returns to EMPTY on an output transfer with no new request.
- Arithmetic wraps; the block never saturates. Overflow is reported only through `out_ovf`.

## Timing
- Reset (asynchronous assert, synchronous release): `out_valid`=0, `out_data`=0, `out_id`=0, `out_ovf`=0, `ptr`=0, `lock_vld`=0. `req_ready`=0 while `rst_n`=0.
- Latency: a request accepted at edge N has `out_valid`=1 with its result after edge N, one cycle.
- `req_ready` is combinational from `req_valid`, `ptr`, lock, `out_valid` and `out_ready`. It has no dependency on the operand values.
- `out_*` are registered; there is no combinational path from inputs to `out_*`.
- Reset asserted mid-stall: the pending result is dropped and the lock cleared. After release, the winning requester (still holding valid) is accepted in the first cycle.
- `NUM_REQ` that is not a power of two: the pointer wraps from `NUM_REQ`−1 to 0 and never holds an out-of-range index.

## Test plan
- Single request: reset, `out_ready`=1, `req_valid`=0001, a0=100, b0=30 → `req_ready`=0001 for one cycle. Next cycle `out_valid`=1, `out_data`=70, `out_id`=0, `out_ovf`=0.
- Round robin: all four valid every cycle, `out_ready`=1 → grants 0,1,2,3,0 on consecutive cycles. `out_id` sequence 0,1,2,3 with no bubbles.
- Back-pressure and lock: `out_ready`=0 while requester 2 is granted, then raise `req_valid[0]` → grant stays 2 and `out_data` is stable. After `out_ready`=1, requester 2 is accepted, then requester 3 is served before requester 0.
- Overflow and wrap at 22 bits: a=0x1FFFFF (+2097151), b=0x3FFFFF (−1) → `out_data`=0x200000, `out_ovf`=1. a=5, b=7 → `out_data`=0x3FFFFE (−2), `out_ovf`=0.
- Reset mid-stall: assert `rst_n`=0 while FULL and stalled → `out_valid` is 0 immediately (asynchronous) and `ptr`=0. Release with `req_valid`=0100 → requester 2 accepted in the first cycle.
- `NUM_REQ`=3 build: all valid → grants 0,1,2,0. Never an ID of 3.
